// File: rtl/instr_mem.sv
// Instruction memory for the single-cycle core: takes the program as a valid/ready word stream,
// then serves fetches with one cycle of latency and drives the core's halt PC (last_pc).
module instr_mem #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  output logic [31:0] last_pc,
  output logic        loaded,
  output logic        trunc
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Handshake: a load word moves on a posedge where load_valid && load_ready are both high;
  // load_data and load_last are sampled on that same edge. load_ready is high only in LOAD.
  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e            state_q;
  logic [ADDR_W:0]   wr_cnt_q;
  logic              load_ready_q;
  logic              loaded_q;
  logic              trunc_q;
  logic [31:0]       last_pc_q;
  logic [31:0]       instr_data_q;
  logic [31:0]       mem_q [DEPTH];

  logic              accept;
  logic              at_end;
  logic              addr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  assign accept  = load_valid && (state_q == S_LOAD);
  assign at_end  = (wr_cnt_q == (ADDR_W + 1)'(DEPTH - 1));
  assign wr_addr = wr_cnt_q[ADDR_W-1:0];
  assign rd_addr = instr_addr[ADDR_W-1:0];
  assign addr_ok = ((instr_addr >> ADDR_W) == 32'd0);

  // last_pc stays at all-ones during LOAD, which parks the core at its reset PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      wr_cnt_q     <= '0;
      load_ready_q <= 1'b1;
      loaded_q     <= 1'b0;
      trunc_q      <= 1'b0;
      last_pc_q    <= 32'hFFFF_FFFF;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (load_last || at_end) begin
              state_q      <= S_RUN;
              last_pc_q    <= 32'(wr_cnt_q);
              load_ready_q <= 1'b0;
              loaded_q     <= 1'b1;
              trunc_q      <= ~load_last;
            end
          end
        end
        S_RUN:   state_q <= S_RUN;
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Plain write port and registered read port so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      mem_q[wr_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_data_q <= '0;
    end else if ((state_q == S_RUN) && addr_ok) begin
      instr_data_q <= mem_q[rd_addr];
    end else begin
      instr_data_q <= '0;
    end
  end

  assign load_ready = load_ready_q;
  assign loaded     = loaded_q;
  assign trunc      = trunc_q;
  assign last_pc    = last_pc_q;
  assign instr_data = instr_data_q;

endmodule

// File: doc/instr_mem.md
Name: instr_mem

Overview:
- Instruction-side responder for the single-cycle CPU.
- Accepts a program as a valid/ready word stream and stores it in on-chip word memory.
- Then serves fetches: the core drives the word address, and the block returns the word one clock later.
- Drives the core's last_pc input. While loading, last_pc parks the core at its reset PC; after the load it equals the index of the last program word.

Parameters:
ADDR_W, 10, word-address width; memory depth DEPTH = 2**ADDR_W 32-bit words

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
load_valid  input  1  load stream word valid
load_ready  output  1  block can accept a load word
load_data  input  32  program word
load_last  input  1  qualifies final program word, sampled with load_valid
instr_addr  input  32  fetch word address from core (core's pc_next)
instr_data  output  32  fetched word, registered
last_pc  output  32  halt PC for the core
loaded  output  1  program loaded, fetch active
trunc  output  1  load stopped at DEPTH words without load_last

Behaviour:
- Reset is synchronous and active-low: rst_n sampled low at posedge clk.
- Reset values:
  - state = LOAD, wr_cnt = 0, load_ready = 1, loaded = 0, trunc = 0.
  - last_pc = 32'hFFFFFFFF, instr_data = 0.
  - Memory contents are not cleared.
- Core hold during LOAD: last_pc = 32'hFFFFFFFF equals the core's reset PC, so the core's pc_next = pc and it stays parked.
- States:
  - LOAD: load_ready = 1.
    - Accept = load_valid & load_ready at posedge: mem[wr_cnt] <= load_data, wr_cnt <= wr_cnt + 1.
    - Accept with load_last = 1: next state RUN, last_pc <= wr_cnt (zero-extended), load_ready <= 0, loaded <= 1.
    - Accept with wr_cnt == DEPTH-1 and load_last = 0: same transition, and trunc <= 1.
    - load_valid with no accept: no effect.
  - RUN: load_ready = 0.
    - load_valid and load_data are ignored, memory is read-only.
    - State stays RUN until reset. Reload is only possible through rst_n.
- wr_cnt is ADDR_W+1 bits wide and never exceeds DEPTH; the memory cannot overflow.
- Fetch, every posedge, 1-cycle latency:
  - In RUN with instr_addr[31:ADDR_W] == 0: instr_data <= mem[instr_addr[ADDR_W-1:0]].
  - Otherwise (LOAD, or address out of range, including 32'hFFFFFFFF): instr_data <= 0.
- Handoff timing, with the final word accepted at edge t:
  - After t: loaded = 1 and last_pc = N-1, so the core's pc_next becomes 0.
  - Edge t+1: instr_data <= mem[0] as the core's pc becomes 0.
  - No write/read collision is possible, because fetch reads only in RUN.
- In RUN, last_pc is never 32'hFFFFFFFF, since N ≥ 1.
- Reset mid-load or mid-run returns to LOAD with the reset values above. Previously written words remain but are overwritten by the new load.
- Memory is synchronous-write, synchronous-read and single-clock; it must infer block RAM.

Test Plan:
1. Basic load, ADDR_W=10: stream 32'h11111111, 32'h22222222, 32'h33333333 (last on third), valid held high.
   - load_ready drops the cycle after the third accept; loaded=1, last_pc=2, trunc=0.
   - Fetch addr 0,1,2 -> instr_data 11111111, 22222222, 33333333, each one cycle after the address.
2. Back-pressure / gaps: same three words with load_valid low for 2 cycles between words.
   - Identical memory contents and last_pc=2; no writes during idle cycles.
   - With the CPU core attached: core PC trace FFFFFFFF (held), 0, 1, 2, 2, 2...
3. Truncation, ADDR_W=2: stream 6 words A0..A5 with no load_last.
   - Only A0..A3 accepted; load_ready=0 after the 4th accept.
   - last_pc=3, trunc=1; A4/A5 ignored; fetch addr 3 -> A3.
4. Out-of-range / park address, ADDR_W=2, after load:
   - instr_addr = 4 -> instr_data 0.
   - instr_addr = 32'hFFFFFFFF -> instr_data 0.
   - During LOAD, any address -> 0.
5. Reset mid-load: accept 2 words, assert rst_n=0 for 1 cycle.
   - Next cycle: load_ready=1, last_pc=FFFFFFFF, loaded=0, instr_data=0.
   - Reload of 1 word (last) -> last_pc=0, fetch addr 0 returns the new word.
6. Single-word program: one word 32'hDEADBEEF with load_last=1.
   - last_pc=0, loaded=1; fetch addr 0 -> DEADBEEF.
   - load_valid pulses in RUN leave memory and last_pc unchanged.
